// File: rtl/motor_cmd_ramp_pkg.sv
// Shared constants for the motor command path.
// Holds the speed-code geometry, the 100 MHz frame length shared with the
// pulse generator, the ramp FSM state encoding and the input clamp helper.
package motor_cmd_ramp_pkg;

  localparam int unsigned CODE_W              = 5;
  localparam logic [CODE_W-1:0] CODE_MAX      = 5'd30;
  localparam logic [CODE_W-1:0] NEUTRAL       = 5'd15;
  localparam int unsigned FRAME_CYCLES_100MHZ = 1100000;

  typedef enum logic [1:0] {
    StHold,
    StRamp,
    StStop
  } ramp_state_e;

  function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
    return (code > CODE_MAX) ? CODE_MAX : code;
  endfunction

endpackage

// File: rtl/ramp_channel.sv
// One slew-limited speed channel.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   tick           take one frame step toward the target
//   load           capture load_value as the new target
//   load_value     new target code (already clamped)
//   force_neutral  immediate neutral on code and target, clears dwell
//   code           current code to the pulse generator
//   busy           code differs from target or a dwell hold is pending
module ramp_channel
  import motor_cmd_ramp_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic [CODE_W-1:0] load_value,
  input  logic              force_neutral,
  output logic [CODE_W-1:0] code,
  output logic              busy
);

  localparam logic [5:0] Step6    = 6'(STEP);
  localparam logic [5:0] Neutral6 = {1'b0, NEUTRAL};

  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] target_q, target_d;
  logic              dwell_q, dwell_d;
  logic              opposite;
  logic [5:0]        cur6, dst6, dist6, delta6, next6;

  always_comb begin
    opposite = ((code_q > NEUTRAL) && (target_q < NEUTRAL)) ||
               ((code_q < NEUTRAL) && (target_q > NEUTRAL));
    cur6     = {1'b0, code_q};
    // A reversal first heads for neutral only; the far side comes after the dwell.
    dst6     = opposite ? Neutral6 : {1'b0, target_q};
    dist6    = (cur6 > dst6) ? (cur6 - dst6) : (dst6 - cur6);
    delta6   = (dist6 < Step6) ? dist6 : Step6;
    next6    = (cur6 > dst6) ? (cur6 - delta6) : (cur6 + delta6);

    code_d   = code_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    if (force_neutral) begin
      code_d   = NEUTRAL;
      target_d = NEUTRAL;
      dwell_d  = 1'b0;
    end else begin
      if (tick) begin
        if (dwell_q) begin
          dwell_d = 1'b0;
        end else begin
          code_d  = next6[CODE_W-1:0];
          dwell_d = opposite && (next6 == Neutral6);
        end
      end
      // The step above always uses the old target.
      if (load) begin
        target_d = load_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q   <= NEUTRAL;
      target_q <= NEUTRAL;
      dwell_q  <= 1'b0;
    end else begin
      code_q   <= code_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
    end
  end

  assign code = code_q;
  assign busy = (code_q != target_q) || dwell_q;

endmodule

// File: rtl/motor_cmd_ramp.sv
// Dual-channel motor command ramp: accepts MC1/MC2 targets over valid/ready,
// slews each channel one frame step at a time, forces neutral on e-stop and
// ramps to neutral after a command timeout.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   cmd_valid, cmd_ready  command handshake
//   cmd_mc1, cmd_mc2      target codes (clamped to CODE_MAX)
//   estop                 synchronous level e-stop
//   mc1, mc2              current codes to the pulse generator
//   frame_tick            one-cycle pulse at the frame boundary
//   busy                  a channel has not settled on its target
//   timeout_flag          watchdog expired, held until the next accept
module motor_cmd_ramp
  import motor_cmd_ramp_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES   = FRAME_CYCLES_100MHZ,
  parameter int unsigned STEP           = 1,
  parameter int unsigned TIMEOUT_FRAMES = 45
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CODE_W-1:0] cmd_mc1,
  input  logic [CODE_W-1:0] cmd_mc2,
  input  logic              estop,
  output logic [CODE_W-1:0] mc1,
  output logic [CODE_W-1:0] mc2,
  output logic              frame_tick,
  output logic              busy,
  output logic              timeout_flag
);

  localparam int unsigned CntW = $clog2(FRAME_CYCLES);
  localparam int unsigned WdW  = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast    = CntW'(FRAME_CYCLES - 1);
  localparam logic [CntW-1:0] CntPreLast = CntW'(FRAME_CYCLES - 2);
  localparam logic [WdW-1:0]  WdMax      = WdW'(TIMEOUT_FRAMES);

  ramp_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              frame_tick_q;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              timeout_flag_q, timeout_flag_d;
  logic              run, accept, timeout_hit, ch_tick, ch_load;
  logic [CODE_W-1:0] load_value1, load_value2;
  logic              busy1, busy2;

  assign cmd_ready   = (state_q != StStop);
  assign run         = cmd_ready && !estop;
  assign accept      = run && cmd_valid;
  assign timeout_hit = run && frame_tick_q && !accept && (wd_q == WdMax - 1'b1);
  assign ch_tick     = run && frame_tick_q;
  assign ch_load     = accept || timeout_hit;
  assign load_value1 = accept ? clamp_code(cmd_mc1) : NEUTRAL;
  assign load_value2 = accept ? clamp_code(cmd_mc2) : NEUTRAL;

  assign cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;

  always_comb begin
    wd_d           = wd_q;
    timeout_flag_d = timeout_flag_q;
    if (!run) begin
      wd_d = '0;
    end else if (accept) begin
      wd_d           = '0;
      timeout_flag_d = 1'b0;
    end else if (frame_tick_q && (wd_q != WdMax)) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout_hit) begin
      timeout_flag_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold:  if (busy) state_d = StRamp;
      StRamp:  if (!busy) state_d = StHold;
      StStop:  state_d = StHold;
      default: state_d = StStop;
    endcase
    if (estop) begin
      state_d = StStop;
    end
  end

  // Reset parks in STOP so cmd_ready stays low until the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StStop;
      cnt_q          <= '0;
      frame_tick_q   <= 1'b0;
      wd_q           <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      // Registered one cycle early so the pulse lines up with cnt_q == FRAME_CYCLES-1.
      frame_tick_q   <= (cnt_q == CntPreLast);
      wd_q           <= wd_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  ramp_channel #(
    .STEP(STEP)
  ) u_ch1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (ch_tick),
    .load         (ch_load),
    .load_value   (load_value1),
    .force_neutral(estop),
    .code         (mc1),
    .busy         (busy1)
  );

  ramp_channel #(
    .STEP(STEP)
  ) u_ch2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (ch_tick),
    .load         (ch_load),
    .load_value   (load_value2),
    .force_neutral(estop),
    .code         (mc2),
    .busy         (busy2)
  );

  assign frame_tick   = frame_tick_q;
  assign busy         = busy1 || busy2;
  assign timeout_flag = timeout_flag_q;

endmodule
